ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter NOP_WORD, default 32'h0000_0013, instruction word returned for a misaligned fetch.
REQ-002 Parameter CNT_W, default 16, width of the fetch counter.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 pc  in  32  fetch address from the PC register.
REQ-006 req  in  1  fetch request; pc is valid while req=1.
REQ-007 req_rdy  out  1  block accepts a request this cycle.
REQ-008 mem_en  out  1  instruction-memory read strobe (sync memory, 1-cycle read latency).
REQ-009 mem_addr  out  30  word address to memory, equal to pc[31:2].
REQ-010 mem_rdata  in  32  memory read data, valid the cycle after mem_en=1.
REQ-011 instr  out  32  fetched instruction.
REQ-012 pc_out  out  32  address associated with instr.
REQ-013 instr_vld  out  1  instr/pc_out/misalign valid.
REQ-014 instr_rdy  in  1  downstream accepts instr.
REQ-015 misalign  out  1  current instr came from a pc with pc[1:0]!=0.
REQ-016 flush  in  1  abort any in-flight fetch.
REQ-017 fetch_cnt  out  CNT_W  count of completed handshakes (instr_vld & instr_rdy).

Function
REQ-018 FSM states SHALL be IDLE, WAIT, HOLD; req_rdy=1 only in IDLE with flush=0.
REQ-019 IDLE, req=1, pc[1:0]=0, flush=0: mem_en=1 and mem_addr=pc[31:2] combinationally that cycle, pc latched, next state WAIT.
REQ-020 IDLE, req=1, pc[1:0]!=0, flush=0: mem_en=0, instr<=NOP_WORD, pc_out<=pc, misalign<=1, next state HOLD.
REQ-021 WAIT: instr<=mem_rdata, pc_out<=latched pc, misalign<=0, next state HOLD; request latency = 2 cycles from acceptance to instr_vld=1.
REQ-022 HOLD: instr_vld=1; instr, pc_out, misalign SHALL remain stable until instr_rdy=1.
REQ-023 HOLD with instr_rdy=1: handshake completes, next state IDLE; no new request accepted in the same cycle.
REQ-024 mem_en SHALL be 0 in WAIT and HOLD; at most one memory read outstanding.
REQ-025 flush=1 in any state: next state IDLE, request in that cycle not accepted, pending memory data discarded, no handshake counted even if instr_rdy=1.
REQ-026 instr_vld SHALL be 0 outside HOLD.
REQ-027 fetch_cnt SHALL increment by 1 per completed handshake and saturate at all-ones (no wrap).
REQ-028 mem_addr SHALL equal pc[31:2] in all states; only mem_en qualifies it.

Reset
REQ-029 rst=1 at a clock edge SHALL override flush and all other inputs: state IDLE, instr=0, pc_out=0, misalign=0, fetch_cnt=0.
REQ-030 During and after reset, instr_vld=0 and mem_en=0 until a request is accepted; reset mid-WAIT discards the returning read.

Verification
REQ-031 Aligned fetch: pc=32'h0000_0010, req=1 one cycle, mem_rdata=32'h0040_0093 next cycle, instr_rdy=1 -> mem_addr=30'h4, instr_vld at cycle+2, instr=32'h0040_0093, pc_out=32'h10, fetch_cnt=1.
REQ-032 Misaligned: pc=32'hF0F0_F0F2, req=1 -> mem_en never asserted, instr=32'h0000_0013, misalign=1, pc_out=32'hF0F0_F0F2.
REQ-033 Backpressure: instr_rdy=0 for 5 cycles in HOLD -> outputs stable, req_rdy=0, fetch_cnt unchanged; instr_rdy=1 -> IDLE next cycle, fetch_cnt+1.
REQ-034 Flush in WAIT and in HOLD with instr_rdy=1 -> IDLE next cycle, instr_vld=0, fetch_cnt unchanged.
REQ-035 Reset mid-HOLD with fetch_cnt=3 -> next cycle all outputs 0, state IDLE, req accepted the cycle after rst drops.
REQ-036 Saturation: CNT_W=2, 5 back-to-back fetches -> fetch_cnt=3 after the 3rd and remains 3.

Source files
------------

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch stage: issues one sync-memory read per
// request, presents the word with a valid/ready handshake and counts handshakes.
module ifetch_unit #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_i,
  input  logic             req_i,
  output logic             req_rdy_o,
  output logic             mem_en_o,
  output logic [29:0]      mem_addr_o,
  input  logic [31:0]      mem_rdata_i,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc_out_o,
  output logic             instr_vld_o,
  input  logic             instr_rdy_i,
  output logic             misalign_o,
  input  logic             flush_i,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misalign;
  } resp_t;

  state_e            state_q, state_d;
  resp_t             resp_q, resp_d;
  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    resp_d    = resp_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    req_rdy_o = 1'b0;
    mem_en_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i) begin
          req_rdy_o = 1'b1;
          if (req_i) begin
            if (pc_i[1:0] == 2'b00) begin
              mem_en_o = 1'b1;
              pc_d     = pc_i;
              state_d  = WAIT;
            end else begin
              // misaligned fetches never touch memory; a NOP stands in
              resp_d  = '{instr: NOP_WORD, pc: pc_i, misalign: 1'b1};
              state_d = HOLD;
            end
          end
        end
      end
      WAIT: begin
        if (flush_i) state_d = IDLE;
        else begin
          resp_d  = '{instr: mem_rdata_i, pc: pc_q, misalign: 1'b0};
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush_i) state_d = IDLE;
        else if (instr_rdy_i) begin
          state_d = IDLE;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      resp_q  <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_addr_o  = pc_i[31:2];
  assign instr_o     = resp_q.instr;
  assign pc_out_o    = resp_q.pc;
  assign misalign_o  = resp_q.misalign;
  assign instr_vld_o = (state_q == HOLD);
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized + directed bench for ifetch_unit; a wide-counter and a 2-bit
// counter instance share stimulus and are checked against a transaction model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst, req, instr_rdy, flush;
  logic [31:0] pc, mem_rdata;

  logic        req_rdy, mem_en, instr_vld, misalign;
  logic [29:0] mem_addr;
  logic [31:0] instr, pc_out;
  logic [15:0] fetch_cnt;

  logic        s_req_rdy, s_mem_en, s_instr_vld, s_misalign;
  logic [29:0] s_mem_addr;
  logic [31:0] s_instr, s_pc_out;
  logic [1:0]  s_fetch_cnt;

  always #5 clk = ~clk;

  ifetch_unit #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .req_i(req), .req_rdy_o(req_rdy),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .instr_o(instr), .pc_out_o(pc_out), .instr_vld_o(instr_vld),
    .instr_rdy_i(instr_rdy), .misalign_o(misalign), .flush_i(flush),
    .fetch_cnt_o(fetch_cnt));

  ifetch_unit #(.CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .req_i(req), .req_rdy_o(s_req_rdy),
    .mem_en_o(s_mem_en), .mem_addr_o(s_mem_addr), .mem_rdata_i(mem_rdata),
    .instr_o(s_instr), .pc_out_o(s_pc_out), .instr_vld_o(s_instr_vld),
    .instr_rdy_i(instr_rdy), .misalign_o(s_misalign), .flush_i(flush),
    .fetch_cnt_o(s_fetch_cnt));

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a == 30'h4) return 32'h0040_0093;
    return {a[13:0], a[29:12]} ^ 32'h5A5A_C3C3;
  endfunction

  // synchronous instruction memory, one-cycle read latency
  always @(posedge clk) if (mem_en) mem_rdata <= mem_word(mem_addr);

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // transaction-level model: a fetch is either waiting on memory or presented
  bit          m_valid = 0;
  bit          m_pending, m_show;
  logic [31:0] m_pc, m_instr, m_pcout;
  bit          m_mis;
  int          m_cnt, m_cnt2;

  task automatic step(input bit r, input bit rq, input logic [31:0] p,
                      input bit ir, input bit fl);
    bit rdy_e, en_e;
    @(negedge clk);
    rst = r; req = rq; pc = p; instr_rdy = ir; flush = fl;
    #1;
    rdy_e = !m_pending && !m_show && !fl;
    en_e  = rdy_e && rq && (p[1:0] == 2'b00);
    if (m_valid) begin
      chk("req_rdy",   {31'b0, req_rdy},   {31'b0, rdy_e});
      chk("mem_en",    {31'b0, mem_en},    {31'b0, en_e});
      chk("mem_addr",  {2'b0, mem_addr},   {2'b0, p[31:2]});
      chk("instr_vld", {31'b0, instr_vld}, {31'b0, m_show});
      chk("instr",     instr,              m_instr);
      chk("pc_out",    pc_out,             m_pcout);
      chk("misalign",  {31'b0, misalign},  {31'b0, m_mis});
      chk("fetch_cnt", {16'b0, fetch_cnt}, m_cnt);
      chk("s_vld",     {31'b0, s_instr_vld}, {31'b0, m_show});
      chk("s_mem_en",  {31'b0, s_mem_en},  {31'b0, en_e});
      chk("s_cnt",     {30'b0, s_fetch_cnt}, m_cnt2);
    end
    if (r) begin
      m_valid = 1; m_pending = 0; m_show = 0;
      m_pc = 0; m_instr = 0; m_pcout = 0; m_mis = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (fl) begin
      m_pending = 0; m_show = 0;
    end else if (m_show) begin
      if (ir) begin
        m_show = 0;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end else if (m_pending) begin
      m_pending = 0; m_show = 1;
      m_instr = mem_word(m_pc[31:2]); m_pcout = m_pc; m_mis = 0;
    end else if (rq) begin
      if (p[1:0] != 2'b00) begin
        m_show = 1; m_instr = 32'h0000_0013; m_pcout = p; m_mis = 1;
      end else begin
        m_pending = 1; m_pc = p;
      end
    end
  endtask

  task automatic fetch(input logic [31:0] p);
    step(0, 1, p, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
  endtask

  initial begin
    rst = 1; req = 0; pc = 0; instr_rdy = 0; flush = 1;
    step(1, 0, 0, 0, 1);
    step(1, 1, 32'h40, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_cnt", {16'b0, fetch_cnt}, 32'h0);

    // aligned fetch
    step(0, 1, 32'h0000_0010, 1, 0);
    chk("al_addr", {2'b0, mem_addr}, 32'h4);
    chk("al_en", {31'b0, mem_en}, 32'h1);
    step(0, 0, 0, 1, 0);
    chk("al_lat1", {31'b0, instr_vld}, 32'h0);
    step(0, 0, 0, 1, 0);
    chk("al_vld", {31'b0, instr_vld}, 32'h1);
    chk("al_instr", instr, 32'h0040_0093);
    chk("al_pc", pc_out, 32'h10);
    step(0, 0, 0, 0, 0);
    chk("al_cnt", {16'b0, fetch_cnt}, 32'h1);

    // misaligned fetch
    step(0, 1, 32'hF0F0_F0F2, 0, 0);
    chk("mis_en", {31'b0, mem_en}, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("mis_instr", instr, 32'h0000_0013);
    chk("mis_flag", {31'b0, misalign}, 32'h1);
    chk("mis_pc", pc_out, 32'hF0F0_F0F2);

    // backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 32'h100, 0, 0);
      chk("bp_instr", instr, 32'h0000_0013);
      chk("bp_rdy", {31'b0, req_rdy}, 32'h0);
      chk("bp_cnt", {16'b0, fetch_cnt}, 32'h1);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("bp_idle", {31'b0, instr_vld}, 32'h0);
    chk("bp_cnt2", {16'b0, fetch_cnt}, 32'h2);

    // flush in WAIT, then flush in HOLD with instr_rdy high
    step(0, 1, 32'h200, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("fw_vld", {31'b0, instr_vld}, 32'h0);
    chk("fw_cnt", {16'b0, fetch_cnt}, 32'h2);
    step(0, 1, 32'h204, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("fh_vld", {31'b0, instr_vld}, 32'h0);
    chk("fh_cnt", {16'b0, fetch_cnt}, 32'h2);

    // reset mid-HOLD with count 3
    fetch(32'h300);
    step(0, 1, 32'h304, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rh_pre", {16'b0, fetch_cnt}, 32'h3);
    step(1, 0, 0, 1, 1);
    step(0, 1, 32'h308, 1, 0);
    chk("rh_instr", instr, 32'h0);
    chk("rh_pc", pc_out, 32'h0);
    chk("rh_cnt", {16'b0, fetch_cnt}, 32'h0);
    chk("rh_acc", {31'b0, mem_en}, 32'h1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // counter saturation on the 2-bit instance
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      fetch(32'h1000 + 32'(i) * 4);
      step(0, 0, 0, 0, 0);
      if (i == 2) chk("sat3", {30'b0, s_fetch_cnt}, 32'h3);
    end
    chk("sat5", {30'b0, s_fetch_cnt}, 32'h3);
    chk("wide5", {16'b0, fetch_cnt}, 32'h5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = $urandom;
      if ($urandom_range(0, 4) != 0) rp[1:0] = 2'b00;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, rp,
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
